// File: rtl/dsp_pkg.sv
// Shared DSP types and width/rounding helpers used by the filter-chain stages.
package dsp_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned ACC_W(input int unsigned data_width, input int unsigned decim);
    return data_width + $clog2(decim);
  endfunction

  // Half an LSB of the decimated result, i.e. 2^(log2(decim)-1).
  function automatic int unsigned round_const(input int unsigned decim);
    return decim >> 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    remain;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + PW'(pop_ok);
  assign remain  = count - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // The head register is loaded from the slot that becomes the head next
  // cycle, or straight from wdata when the FIFO would otherwise be empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_next;
      count  <= remain + CW'(push_ok);
      if (remain != '0) begin
        rdata <= mem[rd_next];
      end else if (push_ok) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/decim_integrate_dump.sv
// Integrate-and-dump decimator: averages blocks of DECIM valid samples into a
// ready/valid output FIFO. Define DECIM_ROUND_EN for round-half-up averaging.
module decim_integrate_dump
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_W,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  input  logic                         sync_clr,
  input  logic                         ovf_clr,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         overflow
);

  localparam int unsigned SH = $clog2(DECIM);
  localparam int unsigned AW = ACC_W(DATA_WIDTH, DECIM);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [SH-1:0]         ph;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  din_ext;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  rounded;
  logic signed [AW-1:0]  shifted;
  logic                  last;
  logic                  dump;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;
  logic [CW-1:0]         fill_unused;

  assign din_ext = {{SH{data_in[DATA_WIDTH-1]}}, data_in};
  assign last    = (ph == SH'(DECIM - 1));
  assign sum     = acc + din_ext;

`ifdef DECIM_ROUND_EN
  localparam logic signed [AW-1:0] RC = AW'(round_const(DECIM));
  assign rounded = sum + RC;
`else
  assign rounded = sum;
`endif

  assign shifted   = rounded >>> SH;
  assign dump      = valid_in && last && !sync_clr;
  assign pop       = valid_out && ready_in;
  assign drop      = dump && full && !pop;
  assign valid_out = !empty;

  // A clear together with a sample starts the new block with that sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  <= '0;
      acc <= '0;
    end else if (sync_clr) begin
      if (valid_in) begin
        acc <= din_ext;
        ph  <= SH'(1);
      end else begin
        acc <= '0;
        ph  <= '0;
      end
    end else if (valid_in) begin
      acc <= (ph == '0) ? din_ext : sum;
      ph  <= ph + SH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .pop   (pop),
    .wdata (shifted[DATA_WIDTH-1:0]),
    .rdata (data_out),
    .full  (full),
    .empty (empty),
    .count (fill_unused)
  );

endmodule

// File: tb/tb_decim_integrate_dump.sv
// Self-checking bench for decim_integrate_dump (DECIM=4, FIFO_DEPTH=4);
// expectations follow DECIM_ROUND_EN when the macro is defined.
module tb_decim_integrate_dump;
  import dsp_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DECIM = 4;
  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] data_in;
  logic                 valid_in;
  logic                 sync_clr;
  logic                 ovf_clr;
  logic signed [DW-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;
  int exp_q[$];

  typedef struct {
    int s0, s1, s2, s3;
    int exp_trunc;
    int exp_round;
    bit gap;
  } vec_t;

  decim_integrate_dump #(
    .DATA_WIDTH (DW),
    .DECIM      (DECIM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .sync_clr  (sync_clr),
    .ovf_clr   (ovf_clr),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int t, input int r);
`ifdef DECIM_ROUND_EN
    return r;
`else
    return t;
`endif
  endfunction

  task automatic step(input int d, input bit v, input bit clr);
    data_in  = DW'(d);
    valid_in = v;
    sync_clr = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
  endtask

  // Four equal samples; the block average is the sample itself.
  task automatic block(input int v, input bit expect_push);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && expect_push) exp_q.push_back(v);
      step(v, 1'b1, 1'b0);
    end
  endtask

  // Scoreboard: each accepted output word is compared to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0d expected no output", data_out);
      end else begin
        check("sb_data", data_out, exp_q.pop_front());
      end
      n_popped++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   p0;

    vecs[0] = '{1, 2, 3, 4, 2, 3, 1'b0};
    vecs[1] = '{-1, -1, -1, -2, -2, -1, 1'b1};
    vecs[2] = '{32767, 32767, 32767, 32767, 32767, 32767, 1'b0};
    vecs[3] = '{-32768, -32768, -32768, -32768, -32768, -32768, 1'b1};
    vecs[4] = '{5, 6, 7, 8, 6, 7, 1'b0};
    vecs[5] = '{3, -3, 2, -3, -1, 0, 1'b1};
    vecs[6] = '{-100, 50, -7, 3, -14, -13, 1'b0};

    rst = 1'b1; data_in = '0; valid_in = 1'b0; sync_clr = 1'b0;
    ovf_clr = 1'b0; ready_in = 1'b1;
    #12;
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp with latency checks
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) exp_q.push_back(pick(2, 3));
      if (i == 8) exp_q.push_back(pick(6, 7));
      step(i, 1'b1, 1'b0);
      if (i == 3) check("ramp_lat_before", valid_out, 0);
      if (i == 4) check("ramp_lat_first", valid_out, 1);
      if (i == 7) check("ramp_drained", valid_out, 0);
      if (i == 8) check("ramp_lat_second", valid_out, 1);
    end
    idle(2);

    // Table vectors, odd entries with idle cycles between samples
    foreach (vecs[v]) begin
      int s[4];
      s[0] = vecs[v].s0; s[1] = vecs[v].s1; s[2] = vecs[v].s2; s[3] = vecs[v].s3;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back(pick(vecs[v].exp_trunc, vecs[v].exp_round));
        step(s[k], 1'b1, 1'b0);
        if (vecs[v].gap) idle(1);
      end
    end
    idle(3);
    check("table_sb_empty", exp_q.size(), 0);

    // sync_clr with a sample restarts the block at that sample
    p0 = n_popped;
    step(10, 1'b1, 1'b0);
    step(20, 1'b1, 1'b0);
    step(100, 1'b1, 1'b1);
    step(100, 1'b1, 1'b0);
    step(100, 1'b1, 1'b0);
    exp_q.push_back(100);
    step(100, 1'b1, 1'b0);
    idle(3);
    check("clr_out_count", n_popped - p0, 1);

    // sync_clr on the dump sample suppresses the push
    p0 = n_popped;
    step(1, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(8, 1'b1, 1'b1);
    check("clr_dump_no_push", valid_out, 0);
    step(8, 1'b1, 1'b0);
    step(8, 1'b1, 1'b0);
    exp_q.push_back(8);
    step(8, 1'b1, 1'b0);
    idle(3);
    check("clr_dump_out_count", n_popped - p0, 1);

    // sync_clr alone discards the partial sum
    step(5, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1);
    block(9, 1'b1);
    idle(3);
    check("clr_alone_sb_empty", exp_q.size(), 0);

    // Back-pressure: 6 blocks into a 4-deep FIFO
    ready_in = 1'b0;
    for (int b = 0; b < 6; b++) begin
      block(100 * (b + 1), b < 4);
      if (b >= 1) begin
        check("bp_hold_data", data_out, 100);
        check("bp_hold_valid", valid_out, 1);
      end
    end
    check("bp_overflow", overflow, 1);
    ready_in = 1'b1;
    idle(3);
    check("bp_drain3_valid", valid_out, 1);
    idle(1);
    check("bp_drain4_empty", valid_out, 0);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("bp_ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the dump cycle
    ready_in = 1'b0;
    for (int b = 1; b <= 4; b++) block(10 * b, 1'b1);
    step(50, 1'b1, 1'b0);
    step(50, 1'b1, 1'b0);
    step(50, 1'b1, 1'b0);
    exp_q.push_back(50);
    ready_in = 1'b1;
    step(50, 1'b1, 1'b0);
    ready_in = 1'b0;
    check("fp_overflow", overflow, 0);
    check("fp_head", data_out, 20);
    ready_in = 1'b1;
    idle(3);
    check("fp_drain3_valid", valid_out, 1);
    idle(1);
    check("fp_drain4_empty", valid_out, 0);
    check("fp_sb_empty", exp_q.size(), 0);

    // Drop coinciding with ovf_clr keeps overflow set
    ready_in = 1'b0;
    for (int b = 1; b <= 4; b++) block(b, 1'b1);
    block(5, 1'b0);
    check("drop_overflow", overflow, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("drop_ovf_cleared", overflow, 0);
    for (int k = 0; k < 3; k++) step(6, 1'b1, 1'b0);
    ovf_clr = 1'b1;
    step(6, 1'b1, 1'b0);
    ovf_clr = 1'b0;
    check("drop_and_clr_overflow", overflow, 1);

    // Asynchronous reset mid-block
    step(3, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_valid_out", valid_out, 0);
    check("arst_overflow", overflow, 0);
    check("arst_data_out", data_out, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    block(7, 1'b1);
    idle(3);

    check("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
